// File: rtl/ooo_rename_pkg.sv
// Shared rename-stage definitions: register-file sizing, lane counts and tag types
// used by the free list, the rename map table and the ROB.
package ooo_rename_pkg;

  localparam int NUM_PHYS_REGS = 32'd64;
  localparam int NUM_ARCH_REGS = 32'd32;
  localparam int TAG_WIDTH     = $clog2(NUM_PHYS_REGS);
  localparam int ALLOC_WIDTH   = 32'd2;
  localparam int RET_WIDTH     = 32'd2;
  localparam int NUM_CKPT      = 32'd4;
  localparam int FL_DEPTH      = NUM_PHYS_REGS - NUM_ARCH_REGS;

  typedef logic [TAG_WIDTH-1:0]         phys_tag_t;
  typedef logic [$clog2(NUM_CKPT)-1:0]  ckpt_id_t;

  // True when v is a non-zero power of two (circular-buffer pointer wrap relies on it).
  function automatic bit is_pow2(input int v);
    return (v > 32'sd0) && ((v & (v - 32'sd1)) == 32'sd0);
  endfunction

endpackage

// File: rtl/free_list_mw_chk.sv
// Checker for the free list: configuration sanity at elaboration and a run-time
// check that commit never returns more tags than the list has room for.
module free_list_mw_chk #(
  parameter int DEPTH = ooo_rename_pkg::FL_DEPTH
) (
  input logic clk,
  input logic rst,
  input logic ret_ovf
);
  import ooo_rename_pkg::*;

  generate
    if (!is_pow2(DEPTH)) begin : g_bad_depth
      $error("free_list_mw: NUM_PHYS_REGS-NUM_ARCH_REGS must be a power of two");
    end
  endgenerate

  // Returned tags beyond the list capacity are dropped by the RTL; flag it.
  ret_no_overflow: assert property (@(posedge clk) disable iff (rst) !ret_ovf)
    else $error("free_list_mw: return group exceeds free-list capacity");

endmodule

// File: rtl/free_list_prefix_cnt.sv
// Exclusive prefix popcount over N request lanes plus the total count.
// prefix[i] = number of set bits in vec[i-1:0]; used to compact lanes onto
// consecutive free-list slots.
module free_list_prefix_cnt #(
  parameter int N  = 32'd2,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]    vec,
  output logic [N*CW-1:0] prefix,
  output logic [CW-1:0]   total
);

  logic [CW-1:0] acc_s;

  // Running sum across lanes: each lane sees the count of set lanes below it.
  always_comb begin
    acc_s  = '0;
    prefix = '0;
    for (int i = 0; i < N; i++) begin
      prefix[i*CW +: CW] = acc_s;
      acc_s              = acc_s + CW'(vec[i]);
    end
    total = acc_s;
  end

endmodule

// File: rtl/free_list_mw.sv
// Multi-way physical-register free list. Circular buffer of free tags with
// wrap-bit head/tail pointers: rename pops up to ALLOC_WIDTH tags per cycle
// (all-or-nothing), commit pushes up to RET_WIDTH tags per cycle, and branch
// checkpoints snapshot the head so a mispredict reclaims speculative tags.
module free_list_mw #(
  parameter int NUM_PHYS_REGS = ooo_rename_pkg::NUM_PHYS_REGS,
  parameter int NUM_ARCH_REGS = ooo_rename_pkg::NUM_ARCH_REGS,
  parameter int TAG_WIDTH     = ooo_rename_pkg::TAG_WIDTH,
  parameter int ALLOC_WIDTH   = ooo_rename_pkg::ALLOC_WIDTH,
  parameter int RET_WIDTH     = ooo_rename_pkg::RET_WIDTH,
  parameter int NUM_CKPT      = ooo_rename_pkg::NUM_CKPT
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [ALLOC_WIDTH-1:0]                          alloc_req,
  output logic                                            alloc_ok,
  output logic [ALLOC_WIDTH*TAG_WIDTH-1:0]                alloc_tag,
  input  logic [RET_WIDTH-1:0]                            ret_valid,
  input  logic [RET_WIDTH*TAG_WIDTH-1:0]                  ret_tag,
  input  logic                                            ckpt_save,
  input  logic [$clog2(NUM_CKPT)-1:0]                     ckpt_save_id,
  input  logic                                            ckpt_restore,
  input  logic [$clog2(NUM_CKPT)-1:0]                     ckpt_restore_id,
  output logic [$clog2(NUM_PHYS_REGS-NUM_ARCH_REGS+1)-1:0] free_count,
  output logic                                            empty,
  output logic                                            full
);
  import ooo_rename_pkg::*;

  localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AC_W  = $clog2(ALLOC_WIDTH + 1);
  localparam int RC_W  = $clog2(RET_WIDTH + 1);

  // Free-tag storage and pointers (MSB of each pointer is the wrap bit).
  logic [TAG_WIDTH-1:0] storage_r [DEPTH];
  logic [PTR_W-1:0]     head_r;
  logic [PTR_W-1:0]     tail_r;
  logic [PTR_W-1:0]     ckpt_r [NUM_CKPT];
  logic [CNT_W-1:0]     free_count_r;
  logic                 empty_r;
  logic                 full_r;

  logic [ALLOC_WIDTH*AC_W-1:0] alloc_pfx_s;
  logic [AC_W-1:0]             alloc_n_s;
  logic [RET_WIDTH*RC_W-1:0]   ret_pfx_s;
  logic [RC_W-1:0]             ret_n_s;

  logic                 alloc_ok_s;
  logic [PTR_W-1:0]     head_grant_s;
  logic [PTR_W-1:0]     head_nxt_s;
  logic [PTR_W-1:0]     tail_nxt_s;
  logic [PTR_W-1:0]     cnt_diff_s;
  logic [CNT_W-1:0]     cnt_nxt_s;
  logic [CNT_W-1:0]     room_s;
  logic [CNT_W-1:0]     ret_acc_s;
  logic                 ret_ovf_s;
  logic [RET_WIDTH-1:0] ret_wr_s;
  logic [IDX_W-1:0]     ret_idx_s [RET_WIDTH];

  free_list_prefix_cnt #(.N(ALLOC_WIDTH), .CW(AC_W)) u_alloc_pfx (
    .vec    (alloc_req),
    .prefix (alloc_pfx_s),
    .total  (alloc_n_s)
  );

  free_list_prefix_cnt #(.N(RET_WIDTH), .CW(RC_W)) u_ret_pfx (
    .vec    (ret_valid),
    .prefix (ret_pfx_s),
    .total  (ret_n_s)
  );

  // Grant decision against the start-of-cycle count; a restore blocks allocation.
  always_comb begin
    alloc_ok_s = 1'b0;
    if (rst) begin
      alloc_ok_s = 1'b0;
    end else if (ckpt_restore) begin
      alloc_ok_s = 1'b0;
    end else if (CNT_W'(alloc_n_s) <= free_count_r) begin
      alloc_ok_s = 1'b1;
    end else begin
      alloc_ok_s = 1'b0;
    end
  end

  // Next head: restore overrides, otherwise advance by the granted group size.
  always_comb begin
    head_grant_s = head_r;
    if (alloc_ok_s) begin
      head_grant_s = head_r + PTR_W'(alloc_n_s);
    end else begin
      head_grant_s = head_r;
    end
    if (ckpt_restore) begin
      head_nxt_s = ckpt_r[ckpt_restore_id];
    end else begin
      head_nxt_s = head_grant_s;
    end
  end

  // Per-lane tag: the lane's rank among requesting lanes indexes from the head.
  always_comb begin
    alloc_tag = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      alloc_tag[i*TAG_WIDTH +: TAG_WIDTH] =
        storage_r[head_r[IDX_W-1:0] + IDX_W'(alloc_pfx_s[i*AC_W +: AC_W])];
    end
  end

  // Return compaction: valid lanes land at tail+rank, clipped to the free room.
  always_comb begin
    room_s    = CNT_W'(DEPTH) - free_count_r;
    ret_ovf_s = CNT_W'(ret_n_s) > room_s;
    if (ret_ovf_s) begin
      ret_acc_s = room_s;
    end else begin
      ret_acc_s = CNT_W'(ret_n_s);
    end
    for (int i = 0; i < RET_WIDTH; i++) begin
      ret_wr_s[i]  = ret_valid[i] && (CNT_W'(ret_pfx_s[i*RC_W +: RC_W]) < room_s);
      ret_idx_s[i] = tail_r[IDX_W-1:0] + IDX_W'(ret_pfx_s[i*RC_W +: RC_W]);
    end
    tail_nxt_s = tail_r + PTR_W'(ret_acc_s);
    cnt_diff_s = tail_nxt_s - head_nxt_s;
    cnt_nxt_s  = CNT_W'(cnt_diff_s);
  end

  // Pointer and occupancy registers; count/empty/full track tail-head exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r       <= '0;
      tail_r       <= PTR_W'(DEPTH);
      free_count_r <= CNT_W'(DEPTH);
      empty_r      <= 1'b0;
      full_r       <= 1'b1;
    end else begin
      head_r       <= head_nxt_s;
      tail_r       <= tail_nxt_s;
      free_count_r <= cnt_nxt_s;
      empty_r      <= (cnt_nxt_s == '0);
      full_r       <= (cnt_nxt_s == CNT_W'(DEPTH));
    end
  end

  // Checkpoint slots capture the post-grant head; a same-cycle restore wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CKPT; i++) begin
        ckpt_r[i] <= '0;
      end
    end else if (ckpt_save && !ckpt_restore) begin
      ckpt_r[ckpt_save_id] <= head_grant_s;
    end
  end

  // Storage: reset preloads the non-architectural tags, then commit writes returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        storage_r[i] <= TAG_WIDTH'(NUM_ARCH_REGS + i);
      end
    end else begin
      for (int i = 0; i < RET_WIDTH; i++) begin
        if (ret_wr_s[i]) begin
          storage_r[ret_idx_s[i]] <= ret_tag[i*TAG_WIDTH +: TAG_WIDTH];
        end
      end
    end
  end

  assign alloc_ok   = alloc_ok_s;
  assign free_count = free_count_r;
  assign empty      = empty_r;
  assign full       = full_r;

  free_list_mw_chk #(.DEPTH(DEPTH)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .ret_ovf (ret_ovf_s)
  );

endmodule
